// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - BCD change payout sequencer with timed 10/5-unit coin pulses
//
// Purpose: latches a legal BCD balance (0..50, multiples of 5) on a start strobe and
//   pays it out largest coin first, one coin per TICK_DIV-cycle interval, then pulses done.
// Parameters: TICK_DIV - clock cycles per payout interval (>= 2).
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   start                - one-cycle request, honoured only while idle
//   bal_tens, bal_ones   - BCD balance digits
//   hold                 - freezes the interval counter while high
//   busy                 - high while paying out
//   done, err            - one-cycle completion / illegal-balance pulses
//   coin10, coin5        - one-cycle coin pulses
//   disp_tens, disp_ones - remaining balance (0/0 while idle)
//   led                  - payout indicator
// Optional feature: define CHANGE_DISPENSER_LED_EN to drive led from a stretch register;
//   otherwise led is constant zero.
module change_dispenser #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  bal_tens,
  input  logic [3:0]  bal_ones,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        coin10,
  output logic        coin5,
  output logic [3:0]  disp_tens,
  output logic [3:0]  disp_ones,
  output logic [15:0] led
);

  localparam int             CW     = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  RELOAD = CW'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_PAY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_tens, w_tens_nxt;
  logic [3:0]    r_ones, w_ones_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_coin10, w_coin10_nxt;
  logic          r_coin5, w_coin5_nxt;
  logic          w_legal;

  // Tens of 5 is only legal as exactly 50; ones must be 0 or 5.
  assign w_legal = (bal_tens <= 4'd5) &&
                   ((bal_ones == 4'd0) || (bal_ones == 4'd5)) &&
                   !((bal_tens == 4'd5) && (bal_ones != 4'd0));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tens_nxt   = r_tens;
    w_ones_nxt   = r_ones;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_coin10_nxt = 1'b0;
    w_coin5_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_legal) begin
            w_state_nxt = S_PAY;
            w_tens_nxt  = bal_tens;
            w_ones_nxt  = bal_ones;
            w_cnt_nxt   = RELOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_PAY: begin
        if (!hold) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
          end else if (r_tens != 4'd0) begin
            // Guarded decrement: tens never underflows.
            w_coin10_nxt = 1'b1;
            w_tens_nxt   = r_tens - 4'd1;
            w_cnt_nxt    = RELOAD;
          end else if (r_ones != 4'd0) begin
            // Only 0 or 5 can be latched, so non-zero means one 5-unit coin.
            w_coin5_nxt = 1'b1;
            w_ones_nxt  = 4'd0;
            w_cnt_nxt   = RELOAD;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tens   <= 4'd0;
      r_ones   <= 4'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_coin10 <= 1'b0;
      r_coin5  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tens   <= w_tens_nxt;
      r_ones   <= w_ones_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_coin10 <= w_coin10_nxt;
      r_coin5  <= w_coin5_nxt;
    end
  end

  assign busy      = (r_state == S_PAY);
  assign done      = r_done;
  assign err       = r_err;
  assign coin10    = r_coin10;
  assign coin5     = r_coin5;
  assign disp_tens = busy ? r_tens : 4'd0;
  assign disp_ones = busy ? r_ones : 4'd0;

`ifdef CHANGE_DISPENSER_LED_EN
  logic [15:0] r_led;

  // Pattern follows the most recent coin and persists through the interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led <= 16'h0000;
    end else if (w_coin10_nxt) begin
      r_led <= 16'hFFFF;
    end else if (w_coin5_nxt) begin
      r_led <= 16'h00FF;
    end else if (w_done_nxt) begin
      r_led <= 16'h0000;
    end
  end

  assign led = r_led;
`else
  assign led = 16'h0000;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard testbench for change_dispenser
module tb_change_dispenser;

  localparam int TICK = 4;
  localparam int K_C10 = 1, K_C5 = 2, K_DONE = 3, K_ERR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  bal_tens, bal_ones;
  logic        hold;
  logic        busy, done, err, coin10, coin5;
  logic [3:0]  disp_tens, disp_ones;
  logic [15:0] led;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [7:0]  disp;
    logic [15:0] led;
  } exp_t;

  exp_t q[$];

  change_dispenser #(.TICK_DIV(TICK)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bal_tens  (bal_tens),
    .bal_ones  (bal_ones),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .coin10    (coin10),
    .coin5     (coin5),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .led       (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_led(input logic [15:0] v);
`ifdef CHANGE_DISPENSER_LED_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [7:0] d, input logic [15:0] l);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.disp = d;
    e.led  = exp_led(l);
    q.push_back(e);
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic do_start(input logic [3:0] t, input logic [3:0] o);
    start    = 1'b1;
    bal_tens = t;
    bal_ones = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: pops the next expected event whenever any pulse output is seen.
  int   m_n, m_kind;
  exp_t m_e;
  always @(negedge clk) begin
    if (rst) begin
      m_n = int'(done) + int'(err) + int'(coin10) + int'(coin5);
      if (m_n > 0) begin
        checks++;
        m_kind = coin10 ? K_C10 : coin5 ? K_C5 : done ? K_DONE : K_ERR;
        if (m_n > 1) begin
          errors++;
          $display("FAIL pulse_onehot: %0d pulses high at cycle %0d, expected 1", m_n, cyc);
        end else if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", m_kind, cyc);
        end else begin
          m_e = q.pop_front();
          if (m_kind != m_e.kind || cyc != m_e.cyc ||
              {disp_tens, disp_ones} !== m_e.disp || led !== m_e.led) begin
            errors++;
            $display("FAIL event: got kind %0d cyc %0d disp %h led %h, expected kind %0d cyc %0d disp %h led %h",
                     m_kind, cyc, {disp_tens, disp_ones}, led, m_e.kind, m_e.cyc, m_e.disp, m_e.led);
          end
        end
      end
    end
  end

  int k;
  logic [7:0] bad [3];

  initial begin
    rst = 1'b0; start = 1'b0; bal_tens = 4'd0; bal_ones = 4'd0; hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {done, err, coin10, coin5}, 0);
    chk("reset_disp", {disp_tens, disp_ones}, 0);
    chk("reset_led", led, 0);
    rst = 1'b1;
    @(negedge clk);

    // Nominal 45
    k = cyc + 1;
    push(K_C10, k + 4,  8'h35, 16'hFFFF);
    push(K_C10, k + 8,  8'h25, 16'hFFFF);
    push(K_C10, k + 12, 8'h15, 16'hFFFF);
    push(K_C10, k + 16, 8'h05, 16'hFFFF);
    push(K_C5,  k + 20, 8'h00, 16'h00FF);
    push(K_DONE, k + 24, 8'h00, 16'h0000);
    do_start(4'd4, 4'd5);
    chk("n45_busy", busy, 1);
    chk("n45_disp", {disp_tens, disp_ones}, 8'h45);
    wait_to(k + 23);
    chk("n45_busy_before_done", busy, 1);
    wait_to(k + 24);
    chk("n45_busy_after", busy, 0);
    chk("n45_disp_after", {disp_tens, disp_ones}, 0);
    @(negedge clk);

    // Illegal balances
    bad[0] = 8'h55; bad[1] = 8'h47; bad[2] = 8'h60;
    for (int i = 0; i < 3; i++) begin
      k = cyc + 1;
      push(K_ERR, k, 8'h00, 16'h0000);
      do_start(bad[i][7:4], bad[i][3:0]);
      chk("ill_busy", busy, 0);
      chk("ill_disp", {disp_tens, disp_ones}, 0);
      @(negedge clk);
    end

    // Zero balance
    k = cyc + 1;
    push(K_DONE, k + 4, 8'h00, 16'h0000);
    do_start(4'd0, 4'd0);
    chk("zero_busy", busy, 1);
    chk("zero_disp", {disp_tens, disp_ones}, 0);
    wait_to(k + 4);
    chk("zero_busy_after", busy, 0);

    // Maximum 50; started on the cycle after done
    k = cyc + 1;
    push(K_C10, k + 4,  8'h40, 16'hFFFF);
    push(K_C10, k + 8,  8'h30, 16'hFFFF);
    push(K_C10, k + 12, 8'h20, 16'hFFFF);
    push(K_C10, k + 16, 8'h10, 16'hFFFF);
    push(K_C10, k + 20, 8'h00, 16'hFFFF);
    push(K_DONE, k + 24, 8'h00, 16'h0000);
    do_start(4'd5, 4'd0);
    chk("max_disp", {disp_tens, disp_ones}, 8'h50);
    wait_to(k + 24);
    chk("max_busy_after", busy, 0);
    @(negedge clk);

    // Hold plus ignored start during PAY
    k = cyc + 1;
    push(K_C10, k + 7,  8'h05, 16'hFFFF);
    push(K_C5,  k + 11, 8'h00, 16'h00FF);
    push(K_DONE, k + 15, 8'h00, 16'h0000);
    do_start(4'd1, 4'd5);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    hold = 1'b0;
    wait_to(k + 8);
    do_start(4'd5, 4'd0);
    chk("hold_led_c10", led, exp_led(16'hFFFF));
    chk("hold_disp_mid", {disp_tens, disp_ones}, 8'h05);
    wait_to(k + 13);
    chk("hold_led_c5", led, exp_led(16'h00FF));
    wait_to(k + 16);
    chk("hold_led_done", led, 0);
    chk("hold_busy_after", busy, 0);

    // Reset mid-payout after the first coin
    k = cyc + 1;
    push(K_C10, k + 4, 8'h35, 16'hFFFF);
    do_start(4'd4, 4'd5);
    wait_to(k + 5);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulses", {done, err, coin10, coin5}, 0);
    chk("mid_rst_disp", {disp_tens, disp_ones}, 0);
    chk("mid_rst_led", led, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_rst_busy_after", busy, 0);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
